odelay_lane_sched: RTL and testbench
====================================

# odelay_lane_sched

Multi-lane scheduler for the DAC5681 output-delay path. Accepts per-lane delay-update requests, grants one lane at a time in round-robin order, and runs the ODELAYE3 VAR_LOAD sequence for the granted lane: drop VTC, wait, pulse LOAD, wait, restore VTC. Sits between the GPIO/register layer and the per-lane ODELAYE3 primitives, which share one update sequencer.

## Interface
- LANES, 16, number of ODELAY lanes (2..32)
- DW, 9, delay tap value width
- WAIT_CYC, 16, clock cycles held in each VTC-low wait phase (≥2)
- clk_125m  in  1  clock; the same clock as the ODELAYE3 CLK
- rst_n  in  1  asynchronous, active-low reset
- req  in  LANES  per-lane update request; a level held until that lane's ack
- req_value  in  LANES*DW  requested value, lane k at [k*DW +: DW]; stable while req[k] is high
- ack  out  LANES  one-cycle completion pulse per lane
- delay_rdy  in  LANES  ODELAYE3 EN_VTC-ready per lane
- delay_monitor  in  LANES*DW  ODELAYE3 CNTVALUEOUT per lane
- delay_vtc  out  LANES  EN_VTC per lane; high when idle
- delay_load  out  LANES  LOAD per lane; low when idle
- delay  out  LANES*DW  CNTVALUEIN per lane, registered
- busy  out  1  high in every state except IDLE
- err  out  1  sticky verify failure (see Configuration)
- err_lane  out  $clog2(LANES)  lane of the most recent verify failure

## Operation
- States:
  - INIT: wait until delay_rdy is all-ones, then go to IDLE.
  - IDLE: if any req is high, grant lane g, chosen round-robin starting from ptr.
    - If req_value[g] == delay_monitor[g] (fast path), go to DONE.
    - Otherwise go to VTC_LOW.
  - VTC_LOW: lasts WAIT_CYC cycles, then go to LOAD.
  - LOAD: lasts 1 cycle, then go to SETTLE.
  - SETTLE: lasts WAIT_CYC cycles, then go to DONE.
  - DONE: lasts 1 cycle, then go to IDLE.
- ptr after grant g: ptr = (g+1) mod LANES. The arbitration wrap from lane LANES-1 to lane 0 is required.
- On entering VTC_LOW:
  - delay_vtc[g] = 0.
  - delay[g] = req_value[g], latched; later changes to req_value are ignored.
- In LOAD, delay_load[g] = 1 for exactly one cycle.
- On entering DONE:
  - delay_vtc[g] = 1.
  - ack[g] = 1 for one cycle.
- Only the granted lane's vtc, load and delay ever change; all other lanes hold their values.
- If req[g] falls mid-sequence, the sequence still completes and ack[g] still pulses.
- A lane must not be re-granted in the same cycle its ack pulses, because IDLE is entered only after DONE.
- Wait counter width is $clog2(WAIT_CYC+1). It clears on every state entry.
- Reset (asynchronous, any state):
  - delay_vtc all 1; delay_load all 0; delay all 0; ack 0.
  - busy 1; err 0; err_lane 0; ptr 0; state INIT.

## Timing
- Cycle 0 is the IDLE cycle in which the grant is made.
- Normal path:
  - Cycles 1..WAIT_CYC: vtc[g] = 0, and delay[g] is valid from cycle 1.
  - Cycle WAIT_CYC+1: load[g] = 1.
  - Cycles WAIT_CYC+2..2*WAIT_CYC+1: SETTLE.
  - Cycle 2*WAIT_CYC+2: vtc[g] = 1 and ack[g] = 1 (DONE).
  - With the defaults, load is at cycle 17 and ack at cycle 34.
- Fast path: ack[g] at cycle 1; vtc and load are never toggled.
- Next grant: earliest at cycle 2*WAIT_CYC+3 on the normal path, cycle 2 on the fast path.
- Reset release with delay_rdy already all-ones: INIT at cycle 0, IDLE at cycle 1, first grant possible at cycle 1.

## Configuration
- Macro: DELAY_VERIFY_EN.
- Defined:
  - In DONE (normal path only), compare delay_monitor[g] against the latched value.
  - On mismatch, set err (sticky until reset) and write err_lane = g.
  - ack still pulses regardless of the compare result.
- Undefined:
  - The compare logic is absent.
  - err and err_lane are tied to 0.

## Structure
- Package odelay_sched_pkg:
  - state enum (INIT, IDLE, VTC_LOW, LOAD, SETTLE, DONE);
  - default constants DW_DEF=9, WAIT_CYC_DEF=16;
  - lane-index width function.
- Sub-module rr_arbiter:
  - inputs: req vector, ptr;
  - outputs: one-hot grant, grant index, any_req;
  - combinational only.

## Test plan
- Single request: reset, then req[3]=1, req_value[3]=9'd100, monitor[3]=0. Required:
  - vtc[3] falls at cycle 1 and delay[3]=100 from cycle 1;
  - load[3] pulses at cycle 17 only;
  - vtc[3] rises and ack[3] pulses at cycle 34;
  - no other lane changes.
- Fast path: req[5] with req_value[5]=monitor[5]=9'd42. Required:
  - ack[5] at cycle 1;
  - vtc[5] stays 1 and load[5] stays 0 throughout.
- Round-robin wrap: after a grant to lane 14, raise req[15], req[0] and req[14] together. Required: grant order 15, 0, 14.
- INIT gating: hold delay_rdy[7]=0 with req[2] asserted. Required:
  - no grant and busy=1 while delay_rdy[7]=0;
  - a grant in the cycle after delay_rdy becomes all-ones.
- Mid-operation reset: assert rst_n=0 during the SETTLE phase of lane 1. Required:
  - vtc all 1, load 0, delay 0, ack 0 asynchronously;
  - state INIT after release.
- Verify (with DELAY_VERIFY_EN): on lane 9, force monitor[9] to a value other than the requested 9'd200. Required:
  - err=1 and err_lane=9 at DONE;
  - ack[9] still pulses;
  - err stays 1 until reset.

Source files
------------

// File: rtl/odelay_sched_pkg.sv
// Shared types and constants for the ODELAYE3 lane update scheduler.
// Optional feature macro: DELAY_VERIFY_EN (read-back verify of the loaded tap value).
package odelay_sched_pkg;

    localparam int unsigned DW_DEF       = 9;
    localparam int unsigned WAIT_CYC_DEF = 16;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        VTC_LOW = 3'd2,
        LOAD    = 3'd3,
        SETTLE  = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Width of a lane index; never narrower than one bit.
    function automatic int unsigned lane_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N  = 16,
    parameter int unsigned LW = 4
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] ptr,
    output logic [N-1:0]  gnt_c,
    output logic [LW-1:0] gnt_idx_c,
    output logic          any_req_c
);

    logic [LW:0] idx;

    // Scan lanes ptr, ptr+1, ... with wrap and keep the first hit.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        any_req_c = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (LW+1)'(ptr) + (LW+1)'(i);
            if (idx >= (LW+1)'(N)) begin
                idx = idx - (LW+1)'(N);
            end
            if (!any_req_c && req[LW'(idx)]) begin
                any_req_c          = 1'b1;
                gnt_idx_c          = LW'(idx);
                gnt_c[LW'(idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/odelay_lane_sched.sv
// Round-robin scheduler running the ODELAYE3 VAR_LOAD sequence
// (VTC low, wait, LOAD pulse, wait, VTC high) for one lane at a time.
// Optional feature macro: DELAY_VERIFY_EN (sticky err on read-back mismatch).
module odelay_lane_sched
    import odelay_sched_pkg::*;
#(
    parameter int unsigned LANES    = 16,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic                     clk_125m,
    input  logic                     rst_n,
    input  logic [LANES-1:0]         req,
    input  logic [LANES*DW-1:0]      req_value,
    output logic [LANES-1:0]         ack,
    input  logic [LANES-1:0]         delay_rdy,
    input  logic [LANES*DW-1:0]      delay_monitor,
    output logic [LANES-1:0]         delay_vtc,
    output logic [LANES-1:0]         delay_load,
    output logic [LANES*DW-1:0]      delay,
    output logic                     busy,
    output logic                     err,
    output logic [$clog2(LANES)-1:0] err_lane
);

    localparam int unsigned LW = lane_w(LANES);
    localparam int unsigned CW = $clog2(WAIT_CYC + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   ptr_q;
    logic [LW-1:0]   gnt_q;

    logic [LANES-1:0] gnt_oh_c;
    logic [LW-1:0]    gnt_idx_c;
    logic             any_req_c;

    logic [DW-1:0] rv_a    [LANES];
    logic [DW-1:0] dm_a    [LANES];
    logic [DW-1:0] delay_q [LANES];

    logic          grant_c;
    logic          start_c;
    logic          load_on_c;
    logic          load_off_c;
    logic          done_c;
    logic [LW-1:0] done_idx_c;

    // Per-lane views of the flat buses.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign rv_a[k]            = req_value[k*DW +: DW];
        assign dm_a[k]            = delay_monitor[k*DW +: DW];
        assign delay[k*DW +: DW]  = delay_q[k];
    end

    rr_arbiter #(
        .N  (LANES),
        .LW (LW)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_c     (gnt_oh_c),
        .gnt_idx_c (gnt_idx_c),
        .any_req_c (any_req_c)
    );

    // State and wait-counter register.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, wait counter and per-transition strobes; counter clears on every state entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        grant_c    = 1'b0;
        start_c    = 1'b0;
        load_on_c  = 1'b0;
        load_off_c = 1'b0;
        done_c     = 1'b0;
        done_idx_c = gnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = '0;
                if (&delay_rdy) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (any_req_c) begin
                    grant_c    = 1'b1;
                    done_idx_c = gnt_idx_c;
                    if (rv_a[gnt_idx_c] == dm_a[gnt_idx_c]) begin
                        state_d = DONE;
                        done_c  = 1'b1;
                    end else begin
                        state_d = VTC_LOW;
                        start_c = 1'b1;
                    end
                end
            end
            VTC_LOW: begin
                if (cnt_q == CW'(WAIT_CYC - 1)) begin
                    state_d   = LOAD;
                    cnt_d     = '0;
                    load_on_c = 1'b1;
                end
            end
            LOAD: begin
                state_d    = SETTLE;
                cnt_d      = '0;
                load_off_c = 1'b1;
            end
            SETTLE: begin
                if (cnt_q == CW'(WAIT_CYC - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    done_c  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered lane outputs; only the granted lane's vtc/load/delay ever move.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            ack        <= '0;
            delay_vtc  <= '1;
            delay_load <= '0;
            busy       <= 1'b1;
            for (int k = 0; k < LANES; k++) begin
                delay_q[k] <= '0;
            end
        end else begin
            ack  <= '0;
            busy <= (state_d != IDLE);
            if (grant_c) begin
                gnt_q <= gnt_idx_c;
                ptr_q <= (gnt_idx_c == LW'(LANES - 1)) ? '0 : gnt_idx_c + LW'(1);
            end
            for (int k = 0; k < LANES; k++) begin
                if (start_c && gnt_oh_c[k]) begin
                    delay_vtc[k] <= 1'b0;
                    delay_q[k]   <= rv_a[k];
                end
            end
            if (load_on_c) begin
                delay_load[gnt_q] <= 1'b1;
            end
            if (load_off_c) begin
                delay_load[gnt_q] <= 1'b0;
            end
            if (done_c) begin
                delay_vtc[done_idx_c] <= 1'b1;
                ack[done_idx_c]       <= 1'b1;
            end
        end
    end

`ifdef DELAY_VERIFY_EN
    // Read-back check of the loaded value, registered on DONE entry so err lines up with ack.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_lane <= '0;
        end else if (done_c && (state_q == SETTLE) && (dm_a[gnt_q] != delay_q[gnt_q])) begin
            err      <= 1'b1;
            err_lane <= gnt_q;
        end
    end
`else
    // Verify logic absent.
    assign err      = 1'b0;
    assign err_lane = '0;
`endif

endmodule

// File: tb/tb_odelay_lane_sched.sv
// Scoreboard bench for odelay_lane_sched: expected acks are queued by the
// stimulus and popped by a forked monitor whenever ack is seen.
module tb_odelay_lane_sched;

    localparam int LANES = 16;
    localparam int DW    = 9;
    localparam int WAIT  = 16;
    localparam int LW    = 4;

    typedef struct {
        int          lane;
        int          cyc;
        logic [8:0]  val;
    } exp_t;

    logic                  clk_125m = 1'b0;
    logic                  rst_n    = 1'b0;
    logic [LANES-1:0]      req      = '0;
    logic [LANES*DW-1:0]   req_value = '0;
    logic [LANES-1:0]      ack;
    logic [LANES-1:0]      delay_rdy = '1;
    logic [LANES*DW-1:0]   delay_monitor = '0;
    logic [LANES-1:0]      delay_vtc;
    logic [LANES-1:0]      delay_load;
    logic [LANES*DW-1:0]   delay;
    logic                  busy;
    logic                  err;
    logic [LW-1:0]         err_lane;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    odelay_lane_sched #(
        .LANES    (LANES),
        .DW       (DW),
        .WAIT_CYC (WAIT)
    ) dut (
        .clk_125m      (clk_125m),
        .rst_n         (rst_n),
        .req           (req),
        .req_value     (req_value),
        .ack           (ack),
        .delay_rdy     (delay_rdy),
        .delay_monitor (delay_monitor),
        .delay_vtc     (delay_vtc),
        .delay_load    (delay_load),
        .delay         (delay),
        .busy          (busy),
        .err           (err),
        .err_lane      (err_lane)
    );

    always #4 clk_125m = ~clk_125m;

    always @(posedge clk_125m) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int k, input logic [8:0] v, input logic [8:0] m);
        req_value[k*DW +: DW]     = v;
        delay_monitor[k*DW +: DW] = m;
    endtask

    function automatic logic [8:0] dslice(input int k);
        return delay[k*DW +: DW];
    endfunction

    // Drop each request as its ack appears; return once all served and the DUT is idle.
    task automatic serve(input int budget);
        int n;
        n = 0;
        forever begin
            @(negedge clk_125m);
            req = req & ~ack;
            if (req == '0 && !busy) break;
            n++;
            if (n >= budget) begin
                chk("serve_timeout", 1, 0);
                req = '0;
                break;
            end
        end
    endtask

    initial begin
        int               c0;
        logic [LANES-1:0] exp_vtc, exp_load;
        logic [LANES*DW-1:0] exp_delay;

        fork
            forever begin
                @(negedge clk_125m);
                if (rst_n && ack !== '0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", ack, 0);
                    end else begin
                        exp_t e;
                        logic [LANES-1:0] oh;
                        e  = sb.pop_front();
                        oh = '0;
                        oh[e.lane] = 1'b1;
                        chk($sformatf("ack_vec lane%0d", e.lane), ack, oh);
                        chk($sformatf("ack_cycle lane%0d", e.lane), cyc, e.cyc);
                        chk($sformatf("ack_delay lane%0d", e.lane), dslice(e.lane), e.val);
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk_125m);
        chk("rst_vtc", delay_vtc, {LANES{1'b1}});
        chk("rst_load", delay_load, 0);
        chk("rst_delay", delay, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 1);
        chk("rst_err", {err, err_lane}, 0);
        rst_n = 1'b1;
        @(negedge clk_125m);
        chk("idle_after_release", busy, 0);

        // Single normal-path request on lane 3
        c0 = cyc;
        set_lane(3, 9'd100, 9'd0);
        req[3] = 1'b1;
        sb.push_back('{3, c0 + 2*WAIT + 2, 9'd100});
        for (int t = 1; t <= 2*WAIT + 2; t++) begin
            @(negedge clk_125m);
            exp_vtc   = '1;
            exp_load  = '0;
            exp_delay = '0;
            if (t <= 2*WAIT + 1) exp_vtc[3] = 1'b0;
            if (t == WAIT + 1)   exp_load[3] = 1'b1;
            exp_delay[3*DW +: DW] = 9'd100;
            chk($sformatf("l3 vtc t%0d", t), delay_vtc, exp_vtc);
            chk($sformatf("l3 load t%0d", t), delay_load, exp_load);
            chk($sformatf("l3 delay t%0d", t), delay, exp_delay);
        end
        req[3] = 1'b0;
        @(negedge clk_125m);
        chk("l3 idle after done", busy, 0);

        // Fast path on lane 5
        c0 = cyc;
        set_lane(5, 9'd42, 9'd42);
        req[5] = 1'b1;
        sb.push_back('{5, c0 + 1, 9'd0});
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk_125m);
            chk($sformatf("fast vtc t%0d", t), delay_vtc, {LANES{1'b1}});
            chk($sformatf("fast load t%0d", t), delay_load, 0);
            if (t == 1) req[5] = 1'b0;
        end

        // Grant lane 14, then 15/0/14 together must go 15, 0, 14
        c0 = cyc;
        set_lane(14, 9'd5, 9'd5);
        req[14] = 1'b1;
        sb.push_back('{14, c0 + 1, 9'd0});
        serve(10);
        c0 = cyc;
        set_lane(15, 9'd3, 9'd3);
        set_lane(0, 9'd4, 9'd4);
        req[15] = 1'b1;
        req[0]  = 1'b1;
        req[14] = 1'b1;
        sb.push_back('{15, c0 + 1, 9'd0});
        sb.push_back('{0,  c0 + 3, 9'd0});
        sb.push_back('{14, c0 + 5, 9'd0});
        serve(20);

        // INIT gating on delay_rdy[7]
        rst_n = 1'b0;
        delay_rdy[7] = 1'b0;
        @(negedge clk_125m);
        rst_n = 1'b1;
        set_lane(2, 9'd7, 9'd7);
        req[2] = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk_125m);
            chk($sformatf("init busy t%0d", t), busy, 1);
            chk($sformatf("init no ack t%0d", t), ack, 0);
        end
        c0 = cyc;
        delay_rdy = '1;
        sb.push_back('{2, c0 + 2, 9'd0});
        serve(10);

        // Reset in the SETTLE phase of lane 1
        set_lane(1, 9'd55, 9'd0);
        req[1] = 1'b1;
        repeat (WAIT + 9) @(negedge clk_125m);
        chk("l1 delay pre-reset", dslice(1), 9'd55);
        chk("l1 vtc pre-reset", delay_vtc[1], 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst vtc", delay_vtc, {LANES{1'b1}});
        chk("mid_rst load", delay_load, 0);
        chk("mid_rst delay", delay, 0);
        chk("mid_rst ack", ack, 0);
        chk("mid_rst busy", busy, 1);
        req = '0;
        @(negedge clk_125m);
        rst_n = 1'b1;
        #1;
        chk("post_rst init busy", busy, 1);
        @(negedge clk_125m);
        chk("post_rst idle", busy, 0);

        // Lane 9 with monitor not following the requested value
        c0 = cyc;
        set_lane(9, 9'd200, 9'd199);
        req[9] = 1'b1;
        sb.push_back('{9, c0 + 2*WAIT + 2, 9'd200});
        repeat (2*WAIT + 2) @(negedge clk_125m);
        chk("l9 ack at done", ack[9], 1);
`ifdef DELAY_VERIFY_EN
        chk("l9 err at done", {err, err_lane}, {1'b1, 4'd9});
`else
        chk("l9 err tied off", {err, err_lane}, 0);
`endif
        req[9] = 1'b0;
        @(negedge clk_125m);
        set_lane(6, 9'd11, 9'd11);
        req[6] = 1'b1;
        sb.push_back('{6, cyc + 1, 9'd0});
        serve(10);
`ifdef DELAY_VERIFY_EN
        chk("err sticky", {err, err_lane}, {1'b1, 4'd9});
`else
        chk("err still zero", {err, err_lane}, 0);
`endif
        rst_n = 1'b0;
        #1;
        chk("err cleared by reset", {err, err_lane}, 0);
        @(negedge clk_125m);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_125m);

        chk("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
